// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the BCD countdown timer: FSM state encoding, BCD
// digit width, the largest legal BCD digit, and a helper that clamps a
// single nibble into the legal BCD range.
// No ports (package).
// ---------------------------------------------------------------------------
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] BCD_MAX_DIGIT = 4'd9;

  // Nibbles A..F are not valid BCD; they are pinned to 9 so the count
  // always stays a legal decimal value.
  function automatic logic [BCD_W-1:0] clampNibble(input logic [BCD_W-1:0] nibble);
    return (nibble > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : nibble;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// ---------------------------------------------------------------------------
// bcd_digit_dec
// One stage of a BCD borrow chain. When a borrow arrives the digit is
// decremented; a digit at 0 wraps to 9 and passes the borrow upward.
// Without an incoming borrow the digit passes through unchanged.
// Purely combinational.
//
// Ports:
//   i_digit      in  4  current BCD digit
//   i_borrow_in  in  1  borrow from the next lower digit
//   o_digit      out 4  digit after the borrow is applied
//   o_borrow_out out 1  borrow passed to the next higher digit
// ---------------------------------------------------------------------------
module bcd_digit_dec
  import timer_pkg::*;
(
  input  logic [BCD_W-1:0] i_digit,
  input  logic             i_borrow_in,
  output logic [BCD_W-1:0] o_digit,
  output logic             o_borrow_out
);

  // A borrow into a zero digit is the only case that ripples further up.
  always_comb begin
    o_digit      = i_digit;
    o_borrow_out = 1'b0;
    if (i_borrow_in) begin
      if (i_digit == '0) begin
        o_digit      = BCD_MAX_DIGIT;
        o_borrow_out = 1'b1;
      end else begin
        o_digit = i_digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// ---------------------------------------------------------------------------
// bcd_countdown_timer
// Multi-digit BCD down-counter used as a round timer. The rate divider's
// one-clock pulse arrives on `tick` and is used purely as a count enable.
// Control priority within a cycle is load > pause > start > tick.
//
// Optional feature (macro BCD_COUNTDOWN_AUTO_RELOAD_EN):
//   defined   - on reaching zero the count reloads from the load register
//               in the same cycle and the timer keeps running; done_pulse
//               fires every period and done stays low. A zero load
//               register still ends in DONE.
//   undefined - DONE is terminal until start or load.
//
// Ports:
//   clock       in  1         system clock, rising edge
//   resetn      in  1         asynchronous active-low reset
//   tick        in  1         count enable pulse
//   load        in  1         capture load_value into load register and count
//   load_value  in  4*DIGITS  BCD value, nibbles above 9 clamped to 9
//   start       in  1         begin or resume counting
//   pause       in  1         suspend counting
//   bcd_out     out 4*DIGITS  current count (registered)
//   running     out 1         high while in RUN
//   done        out 1         high while in DONE
//   done_pulse  out 1         one-clock pulse on each reach-zero event
// ---------------------------------------------------------------------------
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int                  DIGITS      = 2,
  parameter logic [4*DIGITS-1:0] RESET_VALUE = 8'h30
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                tick,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  input  logic                start,
  input  logic                pause,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                running,
  output logic                done,
  output logic                done_pulse
);

  localparam int CW = BCD_W * DIGITS;

  state_t          r_state;
  state_t          w_nextState;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_nextCount;
  logic [CW-1:0]   r_loadReg;
  logic [CW-1:0]   w_nextLoadReg;
  logic            r_donePulse;
  logic            w_nextDonePulse;
  logic [CW-1:0]   w_decCount;
  logic [CW-1:0]   w_clamped;
  logic [DIGITS:0] w_borrow;
  logic            w_countZero;
  logic            w_decZero;
  logic [CW-1:0]   w_startCount;
  logic            w_startZero;

  // Borrow chain: the least significant digit always receives a borrow.
  // A borrow escaping the top digit means the count was already zero.
  assign w_borrow[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_dec u_digitDec (
      .i_digit      (r_count[g*BCD_W +: BCD_W]),
      .i_borrow_in  (w_borrow[g]),
      .o_digit      (w_decCount[g*BCD_W +: BCD_W]),
      .o_borrow_out (w_borrow[g+1])
    );
  end

  assign w_countZero = w_borrow[DIGITS];
  assign w_decZero   = (w_decCount == '0);

  // Clamp every nibble of the incoming load value to a legal BCD digit.
  always_comb begin
    w_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_clamped[i*BCD_W +: BCD_W] = clampNibble(load_value[i*BCD_W +: BCD_W]);
    end
  end

  // Restarting from DONE counts again from the load register; from IDLE
  // or PAUSED the current count resumes.
  assign w_startCount = (r_state == DONE) ? r_loadReg : r_count;
  assign w_startZero  = (w_startCount == '0);

  // Next-state logic. Each control input masks all lower-priority inputs,
  // so a start in RUN still swallows a coincident tick.
  always_comb begin
    w_nextState     = r_state;
    w_nextCount     = r_count;
    w_nextLoadReg   = r_loadReg;
    w_nextDonePulse = 1'b0;

    if (load) begin
      w_nextLoadReg = w_clamped;
      w_nextCount   = w_clamped;
      w_nextState   = IDLE;
    end else if (pause) begin
      if (r_state == RUN) begin
        w_nextState = PAUSED;
      end
    end else if (start) begin
      if (r_state != RUN) begin
        w_nextCount = w_startCount;
        if (w_startZero) begin
          w_nextState     = DONE;
          w_nextDonePulse = 1'b1;
        end else begin
          w_nextState = RUN;
        end
      end
    end else if (tick && (r_state == RUN) && !w_countZero) begin
      if (w_decZero) begin
        w_nextDonePulse = 1'b1;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
        if (r_loadReg != '0) begin
          w_nextCount = r_loadReg;
        end else begin
          w_nextCount = w_decCount;
          w_nextState = DONE;
        end
`else
        w_nextCount = w_decCount;
        w_nextState = DONE;
`endif
      end else begin
        w_nextCount = w_decCount;
      end
    end
  end

  // State, count, load register and pulse registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_count     <= RESET_VALUE;
      r_loadReg   <= RESET_VALUE;
      r_donePulse <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_count     <= w_nextCount;
      r_loadReg   <= w_nextLoadReg;
      r_donePulse <= w_nextDonePulse;
    end
  end

  // Outputs come straight from registers, with no path from the inputs.
  assign bcd_out    = r_count;
  assign running    = (r_state == RUN);
  assign done       = (r_state == DONE);
  assign done_pulse = r_donePulse;

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Downstream consumer of the rate divider's one-clock `out_pulse`; that pulse is wired to this block's `tick` input.
- Multi-digit BCD down-counter with load/start/pause control and done signalling.
- Output feeds the HEX display decoders and the game-control FSM (round timer).
- All logic runs on the system clock; `tick` acts only as a count enable, never as a clock.

Parameters:
- DIGITS, 2, number of BCD digits (count range 0 to 10^DIGITS-1).
- RESET_VALUE, 8'h30, BCD value held in the load register after reset; width 4*DIGITS.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- tick  in  1  one-clock enable pulse from the rate divider; one decrement per pulse while running.
- load  in  1  capture `load_value` into the load register and the count.
- load_value  in  4*DIGITS  BCD value; any nibble >9 is clamped to 9 on capture.
- start  in  1  begin or resume counting.
- pause  in  1  suspend counting.
- bcd_out  out  4*DIGITS  current count, registered.
- running  out  1  high in RUN.
- done  out  1  level, high in DONE.
- done_pulse  out  1  one-clock pulse on each reach-zero event.

Behaviour:
- Reset (resetn=0, async): state=IDLE; count=RESET_VALUE; load register=RESET_VALUE; running=0, done=0, done_pulse=0.
- States and transitions:
  - IDLE, PAUSED: start -> RUN.
  - RUN: pause -> PAUSED; tick with count==1 -> DONE.
  - DONE: start -> RUN, count reloaded from the load register.
- Priority within one cycle: load > pause > start > tick.
  - load in any state: count and load register <= clamped `load_value`; state -> IDLE; done cleared.
  - pause and start together: pause wins.
  - start and tick together: start takes effect; that tick is not counted.
- Decrement:
  - Occurs only in RUN on tick; visible on `bcd_out` the cycle after the tick.
  - BCD borrow chain: a digit at 0 becomes 9 and borrows from the next digit.
  - Count never wraps below 0.
- Reach zero:
  - The tick that moves count 1 -> 0 sets state=DONE, done=1, and done_pulse=1 for exactly one cycle, all in the same cycle that count shows 0.
- start with count==0 (zero loaded): RUN is never entered. Next cycle goes to DONE and done_pulse fires once.
- Ticks in IDLE, PAUSED, or DONE are ignored.
- `running` and `done` are decoded from registered state; no combinational path from inputs to outputs.
- resetn asserted mid-count: immediate return to reset values; no done_pulse.

Optional Feature:
- Macro: BCD_COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - On reach-zero, count reloads from the load register in that same cycle; state stays RUN.
  - done_pulse fires each period; done stays 0.
  - A load register of 0 behaves as not defined (goes to DONE).
- Not defined: behaviour exactly as above; DONE is terminal until start or load.

Decomposition:
- Shared package timer_pkg:
  - state enum: IDLE, RUN, PAUSED, DONE.
  - BCD_W = 4.
  - BCD_MAX_DIGIT = 9.
  - Clamp function for a single nibble.
- Sub-module bcd_digit_dec:
  - Inputs: one digit, borrow_in.
  - Outputs: next digit, borrow_out.
  - Purely combinational; instantiated DIGITS times.
- Top keeps the FSM, count register, and load register.

Test Plan:
- Reset: resetn low mid-run -> bcd_out=8'h30, running=0, done=0 asynchronously; no done_pulse.
- Load/run: load 8'h12, start, 12 ticks -> bcd_out steps 12,11,10,09,...,01,00. done_pulse for one cycle with count 00. done=1. running=0.
- Borrow and clamp: load 8'h1F -> captured as 8'h19; run to 8'h10, then tick -> 8'h09.
- Pause: in RUN at 8'h07, assert pause and tick in the same cycle -> PAUSED, count stays 07. Five ticks ignored. start -> resumes at 07.
- Edge cases: load 8'h00 then start -> DONE and one done_pulse the next cycle. start+tick in the same cycle from IDLE at 05 -> count stays 05.
- Auto-reload (macro defined): load 8'h03, start, 9 ticks -> three done_pulses. Count sequence 2,1,3,2,1,3,... done stays 0.
